// File: rtl/serial_sub_32.sv
// Bit-serial subtractor: d = a - b - b_in, BPC bits per clock, LSB first,
// one borrow flop carried between clocks, start/done handshake.
module serial_sub_32 #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Handshake: start is a request sampled only in IDLE; no ready is exposed,
  // busy=1 means any start is dropped. done is a one-cycle valid for d/b_out/ovf.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;

  logic [BPC-1:0]   diff_c;
  logic             br_c;
  logic [WIDTH-1:0] res_next;

  // Ripple borrow chain over the BPC low bits of the operand shift registers.
  always_comb begin
    diff_c = '0;
    br_c   = br_q;
    for (int i = 0; i < BPC; i++) begin
      diff_c[i] = a_sh_q[i] ^ b_sh_q[i] ^ br_c;
      br_c      = (~a_sh_q[i] & b_sh_q[i]) | (~(a_sh_q[i] ^ b_sh_q[i]) & br_c);
    end
    res_next = {diff_c, res_q[WIDTH-1:BPC]};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    d_d     = d_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = b_in;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          count_d = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> BPC;
        b_sh_d  = b_sh_q >> BPC;
        res_d   = res_next;
        br_d    = br_c;
        count_d = count_q + CW'(1);
        // Last chunk: publish the full result straight from the chain.
        if (count_q == CW'(N - 1)) begin
          count_d = '0;
          state_d = ST_DONE;
          done_d  = 1'b1;
          d_d     = res_next;
          b_out_d = br_c;
          ovf_d   = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_q     <= d_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign d         = d_q;
  assign b_out     = b_out_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_sub_32.sv
// Bench for serial_sub_32: BPC=1 and BPC=4 instances side by side against an
// arithmetic reference with cycle-level timing, plus directed literal vectors.
module tb_serial_sub_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [2];
  logic [31:0] a, b;
  logic        b_in;

  logic        busy_o [2];
  logic        done_o [2];
  logic [31:0] d_o    [2];
  logic        bo_o   [2];
  logic        ovf_o  [2];
  logic [1:0]  st_o   [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_sub_32 #(.WIDTH(32), .BPC(1)) u_bpc1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .a(a), .b(b), .b_in(b_in),
    .busy(busy_o[0]), .done(done_o[0]), .d(d_o[0]), .b_out(bo_o[0]),
    .ovf(ovf_o[0]), .state_dbg(st_o[0])
  );

  serial_sub_32 #(.WIDTH(32), .BPC(4)) u_bpc4 (
    .clk(clk), .rst(rst), .start(start_s[1]), .a(a), .b(b), .b_in(b_in),
    .busy(busy_o[1]), .done(done_o[1]), .d(d_o[1]), .b_out(bo_o[1]),
    .ovf(ovf_o[1]), .state_dbg(st_o[1])
  );

  function automatic int ncyc(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  // {ovf, b_out, d} from plain 33-bit unsigned arithmetic.
  function automatic logic [33:0] ref_sub(input logic [31:0] x, input logic [31:0] y,
                                          input logic bi);
    logic [32:0] e;
    e = {1'b0, x} - {1'b0, y} - {32'b0, bi};
    return {(x[31] != y[31]) && (e[31] != x[31]), e};
  endfunction

  // Independent formulation: adder fed with a, ~b, ~b_in; borrow = ~carry.
  function automatic logic [32:0] rca_sub(input logic [31:0] x, input logic [31:0] y,
                                          input logic bi);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, ~y} + {32'b0, ~bi};
    return {~s[32], s[31:0]};
  endfunction

  // Reference model: accepted op shows its result N edges later for one cycle.
  logic        m_busy [2];
  logic        m_done [2];
  int          m_k    [2];
  logic [33:0] m_res  [2];
  logic [33:0] m_pend [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_k[i]    <= 0;
        m_res[i]  <= '0;
      end else if (!m_busy[i]) begin
        m_done[i] <= 1'b0;
        if (start_s[i]) begin
          m_busy[i] <= 1'b1;
          m_k[i]    <= 1;
          m_pend[i] <= ref_sub(a, b, b_in);
        end
      end else begin
        m_k[i] <= m_k[i] + 1;
        if (m_k[i] == ncyc(i)) begin
          m_done[i] <= 1'b1;
          m_res[i]  <= m_pend[i];
        end else if (m_k[i] == ncyc(i) + 1) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic compare_forever();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        check(i == 0 ? "cycle_bpc1" : "cycle_bpc4",
              {28'b0, busy_o[i], done_o[i], ovf_o[i], bo_o[i], d_o[i]},
              {28'b0, m_busy[i], m_done[i], m_res[i]});
    end
  endtask

  // Start both instances; optional glitch start at cycle glitch_at of the op.
  task automatic run_both(input logic [31:0] x, input logic [31:0] y, input logic bi,
                          input logic [31:0] ed, input logic ebo, input logic eovf,
                          input int glitch_at, input string name);
    int lat [2];
    lat = '{-1, -1};
    @(posedge clk); #1;
    a = x; b = y; b_in = bi;
    start_s[0] = 1'b1; start_s[1] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    a = $urandom; b = $urandom; b_in = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start_s[0] = (k == glitch_at); start_s[1] = (k == glitch_at);
      for (int i = 0; i < 2; i++) begin
        if (done_o[i] && lat[i] < 0) begin
          lat[i] = k;
          check({name, "_d"},    64'(d_o[i]),  64'(ed));
          check({name, "_bout"}, 64'(bo_o[i]), 64'(ebo));
          check({name, "_ovf"},  64'(ovf_o[i]), 64'(eovf));
          check({name, "_rca"},  64'({bo_o[i], d_o[i]}), 64'(rca_sub(x, y, bi)));
        end
      end
    end
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    check({name, "_lat_bpc1"}, 64'(lat[0]), 64'(32));
    check({name, "_lat_bpc4"}, 64'(lat[1]), 64'(8));
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy_o[0] || busy_o[1]) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_idle_timeout"}, 64'(k < 100), 64'(1));
  endtask

  initial begin
    int dones [2];
    int lat;
    logic [32:0] r;
    rst = 1'b1;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    a = '0; b = '0; b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    fork compare_forever(); join_none
    for (int i = 0; i < 2; i++)
      check("reset_state", {busy_o[i], done_o[i], bo_o[i], ovf_o[i], d_o[i]}, 64'd0);
    rst = 1'b0;

    // Directed vectors with hand-computed results.
    run_both(32'd123456784, 32'd98765432, 1'b1, 32'd24691351, 1'b0, 1'b0, 0, "t1");
    run_both(32'd98765432, 32'd434893543, 1'b0, 32'd3958839185, 1'b1, 1'b0, 0, "t2");
    run_both(32'd0, 32'd0, 1'b1, 32'd4294967295, 1'b1, 1'b0, 0, "t3_wrap");
    run_both(32'd4294967290, 32'd67, 1'b1, 32'd4294967222, 1'b0, 1'b0, 0, "t3b");
    run_both(32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 0, "t4a");
    run_both(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 0, "t4b");
    run_both(32'h12345678, 32'h12345678, 1'b0, 32'd0, 1'b0, 1'b0, 0, "a_eq_b");
    run_both(32'd123456784, 32'd98765432, 1'b1, 32'd24691351, 1'b0, 1'b0, 5, "t5_ignore");

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    a = 32'd500; b = 32'd7; b_in = 1'b0;
    start_s[0] = 1'b1; start_s[1] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst_mid_busy", 64'(busy_o[i]), 64'd0);
      check("rst_mid_d",    64'(d_o[i]),    64'd0);
    end
    dones = '{0, 0};
    repeat (40) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) dones[i] += int'(done_o[i]);
    end
    check("rst_mid_no_done_bpc1", 64'(dones[0]), 64'd0);
    check("rst_mid_no_done_bpc4", 64'(dones[1]), 64'd0);

    // start held high: one accept every N+2 cycles.
    a = 32'd1000; b = 32'd1; b_in = 1'b0;
    start_s[0] = 1'b1; start_s[1] = 1'b1;
    dones = '{0, 0};
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) dones[i] += int'(done_o[i]);
    end
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    check("held_start_bpc1", 64'(dones[0]), 64'd1);
    check("held_start_bpc4", 64'(dones[1]), 64'd4);
    check("held_start_d", 64'(d_o[1]), 64'd999);
    wait_idle("held");

    // Random operands on the BPC=4 instance.
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom; b_in = 1'($urandom_range(0, 1));
      if (n % 50 == 0) b = a;
      r = rca_sub(a, b, b_in);
      start_s[1] = 1'b1;
      @(posedge clk); #1;
      start_s[1] = 1'b0;
      lat = -1;
      for (int k = 1; k <= 12 && lat < 0; k++) begin
        @(posedge clk); #1;
        if (done_o[1]) lat = k;
      end
      check("rand_lat", 64'(lat), 64'd8);
      check("rand_rca", 64'({bo_o[1], d_o[1]}), 64'(r));
    end
    wait_idle("rand");

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
